// File: rtl/alu_pkg.sv
// Shared command, selector and state encodings for the ALU controller,
// plus the response-flag helpers.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_LDA  = 2'b00,
        OP_LDB  = 2'b01,
        OP_EXEC = 2'b10,
        OP_OUTA = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        SEL_ADD = 3'b000,
        SEL_SUB = 3'b001,
        SEL_AND = 3'b010,
        SEL_OR  = 3'b011,
        SEL_XOR = 3'b100,
        SEL_NOT = 3'b101,
        SEL_SHL = 3'b110,
        SEL_SHR = 3'b111
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam int DATA_W = 8;

    function automatic logic zero_flag(input logic [DATA_W-1:0] value);
        return (value == {DATA_W{1'b0}});
    endfunction

    function automatic logic sign_flag(input logic [DATA_W-1:0] value);
        return value[DATA_W-1];
    endfunction

endpackage

// File: rtl/alu_ctrl.sv
// Command sequencer for an external combinational ALU: holds the A/B operand
// registers, runs one-cycle EXEC operations and returns results over a handshake.
module alu_ctrl
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_sel,
    input  logic        cmd_dst,
    input  logic [7:0]  cmd_imm,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_s,
    input  logic [7:0]  alu_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic        res_z,
    output logic        res_n
);

    state_e      state_r;
    state_e      state_s;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [2:0]  sel_r;
    logic        dst_r;
    logic [7:0]  res_data_r;
    logic        res_z_r;
    logic        res_n_r;
    logic        cmd_ready_r;
    logic        res_valid_r;

    assign alu_a     = a_r;
    assign alu_b     = b_r;
    assign alu_s     = sel_r;
    assign cmd_ready = cmd_ready_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_z     = res_z_r;
    assign res_n     = res_n_r;

    // Next-state decode; loads keep the controller in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_EXEC: state_s = ST_EXEC;
                        OP_OUTA: state_s = ST_RESP;
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: state_s = ST_RESP;
            ST_RESP: begin
                if (res_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register with handshake outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cmd_ready_r <= (state_s == ST_IDLE);
            res_valid_r <= (state_s == ST_RESP);
        end
    end

    // Operand, selector and response registers; EXEC reads pre-write A/B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r        <= 8'h00;
            b_r        <= 8'h00;
            sel_r      <= 3'b000;
            dst_r      <= 1'b0;
            res_data_r <= 8'h00;
            res_z_r    <= 1'b0;
            res_n_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_LDA:  a_r <= cmd_imm;
                            OP_LDB:  b_r <= cmd_imm;
                            OP_EXEC: begin
                                sel_r <= cmd_sel;
                                dst_r <= cmd_dst;
                            end
                            OP_OUTA: begin
                                res_data_r <= a_r;
                                res_z_r    <= zero_flag(a_r);
                                res_n_r    <= sign_flag(a_r);
                            end
                            default: ;
                        endcase
                    end
                end
                ST_EXEC: begin
                    if (dst_r) begin
                        b_r <= alu_out;
                    end else begin
                        a_r <= alu_out;
                    end
                    res_data_r <= alu_out;
                    res_z_r    <= zero_flag(alu_out);
                    res_n_r    <= sign_flag(alu_out);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: models the external ALU, replays directed vectors and
// random commands against a behavioural model, plus backpressure/reset cases.
module tb_alu_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_sel;
    logic       cmd_dst;
    logic [7:0] cmd_imm;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_s;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       res_z, res_n;

    int n_vec  = 0;
    int n_fail = 0;

    // behavioural model state
    int ma, mb, md;
    bit mz, mn;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        int r;
        case (s)
            3'd0:    r = int'(a) + int'(b);
            3'd1:    r = int'(a) - int'(b) + 256;
            3'd2:    r = int'(a & b);
            3'd3:    r = int'(a | b);
            3'd4:    r = int'(a ^ b);
            3'd5:    r = 255 - int'(a);
            3'd6:    r = int'(a) * 2;
            default: r = int'(a) / 2;
        endcase
        return 8'(r % 256);
    endfunction

    // external ALU sitting alongside the controller
    assign alu_out = alu_ref(alu_a, alu_b, alu_s);

    alu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_z(res_z), .res_n(res_n)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ma = 0; mb = 0; md = 0; mz = 1'b0; mn = 1'b0;
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [2:0] sel, input logic dst, input logic [7:0] imm);
        int r;
        case (op)
            2'd0: ma = imm;
            2'd1: mb = imm;
            2'd2: begin
                r = alu_ref(8'(ma), 8'(mb), sel);
                if (dst) mb = r; else ma = r;
                md = r; mz = (r == 0); mn = (r >= 128);
            end
            default: begin
                md = ma; mz = (ma == 0); mn = (ma >= 128);
            end
        endcase
    endtask

    // Called just after a falling edge with res_ready high; returns at a falling edge.
    task automatic apply(input logic [1:0] op, input logic [2:0] sel, input logic dst, input logic [7:0] imm,
                         input int ed, input bit ez, input bit en, input int ea, input int eb);
        check("cmd_ready_before", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_dst = dst; cmd_imm = imm;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (op == 2'd2) begin
            check("exec_no_early_valid", int'(res_valid), 0);
            check("exec_busy_ready", int'(cmd_ready), 0);
            @(negedge clk);
        end
        check("res_valid", int'(res_valid), (op[1] == 1'b1) ? 1 : 0);
        check("res_data", int'(res_data), ed);
        check("res_z", int'(res_z), int'(ez));
        check("res_n", int'(res_n), int'(en));
        check("reg_a", int'(alu_a), ea);
        check("reg_b", int'(alu_b), eb);
        if (op[1] == 1'b1) begin
            @(negedge clk);
            check("resp_done_valid", int'(res_valid), 0);
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [2:0] sel;
        logic       dst;
        logic [7:0] imm;
        int         ed;
        bit         ez;
        bit         en;
        int         ea;
        int         eb;
    } vec_t;

    vec_t tbl[12];
    vec_t v;

    initial begin
        logic [1:0] rop;
        logic [7:0] snap;
        tbl[0]  = '{2'd0, 3'd0, 1'b0, 8'h7F, 8'h00, 1'b0, 1'b0, 8'h7F, 8'h00};
        tbl[1]  = '{2'd1, 3'd0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h7F, 8'h01};
        tbl[2]  = '{2'd2, 3'd0, 1'b0, 8'h00, 8'h80, 1'b0, 1'b1, 8'h80, 8'h01};
        tbl[3]  = '{2'd0, 3'd0, 1'b0, 8'h35, 8'h80, 1'b0, 1'b1, 8'h35, 8'h01};
        tbl[4]  = '{2'd1, 3'd0, 1'b0, 8'h35, 8'h80, 1'b0, 1'b1, 8'h35, 8'h35};
        tbl[5]  = '{2'd2, 3'd1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h35, 8'h00};
        tbl[6]  = '{2'd0, 3'd0, 1'b0, 8'h81, 8'h00, 1'b1, 1'b0, 8'h81, 8'h00};
        tbl[7]  = '{2'd2, 3'd7, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0, 8'h40, 8'h00};
        tbl[8]  = '{2'd3, 3'd0, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0, 8'h40, 8'h00};
        tbl[9]  = '{2'd0, 3'd0, 1'b0, 8'hF0, 8'h40, 1'b0, 1'b0, 8'hF0, 8'h00};
        tbl[10] = '{2'd1, 3'd0, 1'b0, 8'h0F, 8'h40, 1'b0, 1'b0, 8'hF0, 8'h0F};
        tbl[11] = '{2'd2, 3'd3, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 8'hFF, 8'h0F};

        rst_n = 1'b0; res_ready = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_sel = 3'd0; cmd_dst = 1'b0; cmd_imm = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_a", int'(alu_a), 0);
        check("rst_b", int'(alu_b), 0);
        check("rst_s", int'(alu_s), 0);
        check("rst_res_data", int'(res_data), 0);
        check("rst_res_z", int'(res_z), 0);

        // directed vectors (loads run back to back)
        for (int i = 0; i < 12; i++) begin
            v = tbl[i];
            model_cmd(v.op, v.sel, v.dst, v.imm);
            apply(v.op, v.sel, v.dst, v.imm, v.ed, v.ez, v.en, v.ea, v.eb);
        end

        // response backpressure: held result, commands ignored
        res_ready = 1'b0;
        check("bp_ready", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_sel = 3'd0; cmd_dst = 1'b0; cmd_imm = 8'h00;
        model_cmd(2'd2, 3'd0, 1'b0, 8'h00);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("bp_valid_first", int'(res_valid), 1);
        check("bp_data_first", int'(res_data), md);
        snap = res_data;
        for (int k = 0; k < 5; k++) begin
            cmd_valid = 1'b1; cmd_op = 2'd0; cmd_imm = 8'hAA;
            @(negedge clk);
            check("bp_valid_held", int'(res_valid), 1);
            check("bp_data_stable", int'(res_data), int'(snap));
            check("bp_cmd_ready_low", int'(cmd_ready), 0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", int'(res_valid), 0);
        check("bp_release_ready", int'(cmd_ready), 1);
        check("bp_a_not_loaded", int'(alu_a), ma);

        // reset while in EXEC aborts the operation
        model_cmd(2'd0, 3'd0, 1'b0, 8'h10);
        apply(2'd0, 3'd0, 1'b0, 8'h10, md, mz, mn, ma, mb);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_sel = 3'd0; cmd_dst = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_in_exec", int'(cmd_ready), 0);
        rst_n = 1'b0;
        #1;
        check("abort_async_valid", int'(res_valid), 0);
        check("abort_async_a", int'(alu_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("abort_valid", int'(res_valid), 0);
        check("abort_ready", int'(cmd_ready), 1);
        check("abort_a", int'(alu_a), 0);
        check("abort_data", int'(res_data), 0);

        // randomized commands against the model
        for (int i = 0; i < 150; i++) begin
            rop = 2'($urandom_range(0, 3));
            v.op = rop;
            v.sel = 3'($urandom_range(0, 7));
            v.dst = 1'($urandom_range(0, 1));
            v.imm = 8'($urandom_range(0, 255));
            model_cmd(v.op, v.sel, v.dst, v.imm);
            apply(v.op, v.sel, v.dst, v.imm, md, mz, mn, ma, mb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
